// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcode map, ALU latency, response flag layout and request tag shared by the arbiter
package alu_ctrl_pkg;
  localparam int ALU_LAT = 2;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_SEQ = 4'd3, OP_SNE = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5, OP_SRA = 4'd6, OP_SLTU = 4'd7, OP_MAX = 4'd8;
  localparam int FLAG_C = 2, FLAG_Z = 1, FLAG_S = 0;
  typedef struct packed {
    logic valid;
    logic id;
    logic err;
    logic is_arith;
  } tag_t;
  function automatic logic op_supported(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_NAND, OP_SRA, OP_MAX};
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; after reset the last-grant register favours requester 0
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  input  logic       i_hold,
  output logic [1:0] o_grant
);
  logic r_last;
  always_comb o_grant = i_hold ? 2'b00 : (&i_valid) ? (r_last ? 2'b01 : 2'b10) : i_valid;
  always_ff @(posedge clk)
    if (!rst) r_last <= 1'b1;
    else if (|o_grant) r_last <= o_grant[1];
endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one pipelined ALU between two requesters; a tag rides alongside
// the ALU pipeline so each result is routed back, flagged and error-checked in issue order
module alu_req_arbiter #(
  parameter int WIDTH = 16,
  parameter int ALU_LAT = alu_ctrl_pkg::ALU_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [4:0]       req0_shamt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [4:0]       req1_shamt,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [4:0]       alu_shift,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_result,
  output logic [2:0]       rsp0_flags,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [2:0]       rsp1_flags,
  output logic             rsp1_err,
  input  logic             hold,
  output logic             busy
);
  import alu_ctrl_pkg::*;
  logic [1:0]       w_grant;
  tag_t             w_tag;
  tag_t             w_out;
  tag_t             r_tag [ALU_LAT];
  logic             w_live;
  logic [WIDTH-1:0] w_res;
  logic [2:0]       w_flags;
  logic             r_v0, r_v1, r_err;
  logic [WIDTH-1:0] r_res;
  logic [2:0]       r_flags;
  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_valid ({req1_valid, req0_valid}),
    .i_hold  (hold),
    .o_grant (w_grant)
  );
  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  always_comb begin
    alu_opcode = w_grant[1] ? req1_opcode : w_grant[0] ? req0_opcode : 4'd0;
    alu_input1 = w_grant[1] ? req1_a : w_grant[0] ? req0_a : '0;
    alu_input2 = w_grant[1] ? req1_b : w_grant[0] ? req0_b : '0;
    alu_shift  = w_grant[1] ? req1_shamt : w_grant[0] ? req0_shamt : 5'd0;
  end
  assign w_tag = {|w_grant, w_grant[1], ~op_supported(alu_opcode), alu_opcode inside {OP_ADD, OP_SUB}};
  always_ff @(posedge clk)
    if (!rst) for (int i = 0; i < ALU_LAT; i++) r_tag[i] <= '0;
    else begin
      r_tag[0] <= w_tag;
      for (int i = 1; i < ALU_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  // the last tag stage lines up with the cycle in which the ALU presents that request's result
  assign w_out  = r_tag[ALU_LAT-1];
  assign w_live = w_out.valid & ~w_out.err;
  assign w_res  = w_live ? alu_result : '0;
  always_comb begin
    w_flags = '0;
    w_flags[FLAG_C] = w_live & w_out.is_arith & alu_carry;
    w_flags[FLAG_Z] = w_live & ~|w_res;
    w_flags[FLAG_S] = w_res[WIDTH-1];
  end
  always_ff @(posedge clk)
    if (!rst) begin
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
      r_err   <= 1'b0;
      r_res   <= '0;
      r_flags <= '0;
    end else begin
      r_v0    <= w_out.valid & ~w_out.id;
      r_v1    <= w_out.valid & w_out.id;
      r_err   <= w_out.valid & w_out.err;
      r_res   <= w_res;
      r_flags <= w_flags;
    end
  assign rsp0_valid  = r_v0;
  assign rsp1_valid  = r_v1;
  assign rsp0_result = r_v0 ? r_res : '0;
  assign rsp1_result = r_v1 ? r_res : '0;
  assign rsp0_flags  = r_v0 ? r_flags : '0;
  assign rsp1_flags  = r_v1 ? r_flags : '0;
  assign rsp0_err    = r_v0 & r_err;
  assign rsp1_err    = r_v1 & r_err;
  always_comb begin
    busy = r_v0 | r_v1;
    for (int i = 0; i < ALU_LAT; i++) busy = busy | r_tag[i].valid;
  end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: randomized + directed scoreboard bench with a behavioural pipelined ALU
module tb_alu_req_arbiter;
  localparam int W = 16;
  typedef struct {
    logic         v;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   sh;
  } req_t;
  typedef struct {
    int           due;
    logic         id;
    logic         err;
    logic [W-1:0] res;
    logic [2:0]   flags;
  } exp_t;
  logic clk = 0, rst = 0, hold = 0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [3:0] req0_opcode = 0, req1_opcode = 0, alu_opcode;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, alu_input1, alu_input2, alu_result;
  logic [4:0] req0_shamt = 0, req1_shamt = 0, alu_shift;
  logic alu_carry, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy;
  logic [W-1:0] rsp0_result, rsp1_result;
  logic [2:0] rsp0_flags, rsp1_flags;
  logic [W:0] s1 = 0, s2 = 0;
  exp_t q[$];
  exp_t m_e;
  logic m_ev, m_eb;
  logic [1:0] m_expv;
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic last = 1'b1;
  req_t idle;

  alu_req_arbiter #(.WIDTH(W), .ALU_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_shift(alu_shift),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err),
    .hold(hold), .busy(busy)
  );

  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // shared ALU stand-in: two register stages, carry deliberately set for non add/sub ops
  function automatic logic [W:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] sh);
    case (op)
      4'd0: return {1'b0, a} + {1'b0, b};
      4'd1: return {a < b, a - b};
      4'd2: return {1'b1, W'(a * b)};
      4'd5: return {1'b1, ~(a & b)};
      4'd6: return {1'b1, W'($signed(a) >>> sh)};
      4'd8: return {1'b1, (a > b) ? a : b};
      default: return {1'b1, a ^ b ^ 16'h5a5a};
    endcase
  endfunction
  always @(posedge clk) begin
    s1 <= alu_f(alu_opcode, alu_input1, alu_input2, alu_shift);
    s2 <= s1;
    cyc <= cyc + 1;
  end
  assign alu_result = s2[W-1:0];
  assign alu_carry  = s2[W];

  function automatic exp_t ref_rsp(input req_t r, input logic id, input int due);
    exp_t e;
    int unsigned ua = 32'(r.a), ub = 32'(r.b);
    logic [W-1:0] res = '0;
    logic c = 1'b0;
    e.due = due;
    e.id  = id;
    e.err = !(r.op inside {4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd8});
    if (!e.err)
      case (r.op)
        4'd0: begin res = W'(ua + ub); c = (ua + ub) > 32'd65535; end
        4'd1: begin res = W'(ua - ub); c = ua < ub; end
        4'd2: res = W'(ua * ub);
        4'd5: res = W'(32'hffff_ffff - (ua & ub));
        4'd6: res = W'(int'($signed(r.a)) >>> r.sh);
        default: res = (ua > ub) ? r.a : r.b;
      endcase
    e.res   = res;
    e.flags = e.err ? 3'b000 : {c, res == '0, res[W-1]};
    return e;
  endfunction

  function automatic req_t mk(input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] sh);
    req_t r;
    r.v = v; r.op = op; r.a = a; r.b = b; r.sh = sh;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic issue(input req_t r0, input req_t r1, input logic h);
    logic [1:0] eg;
    req_t g;
    int win;
    @(negedge clk);
    rst = 1'b1; hold = h;
    req0_valid = r0.v; req0_opcode = r0.op; req0_a = r0.a; req0_b = r0.b; req0_shamt = r0.sh;
    req1_valid = r1.v; req1_opcode = r1.op; req1_a = r1.a; req1_b = r1.b; req1_shamt = r1.sh;
    #1;
    eg = 2'b00;
    if (!h && (r0.v || r1.v)) begin
      win = (r0.v && r1.v) ? (last ? 0 : 1) : (r1.v ? 1 : 0);
      eg[win] = 1'b1;
    end
    g = eg[1] ? r1 : eg[0] ? r0 : mk(1'b0, 4'd0, '0, '0, 5'd0);
    chk("ready", 32'({req1_ready, req0_ready}), 32'(eg));
    chk("alu_opcode", 32'(alu_opcode), 32'(g.op));
    chk("alu_input1", 32'(alu_input1), 32'(g.a));
    chk("alu_input2", 32'(alu_input2), 32'(g.b));
    chk("alu_shift", 32'(alu_shift), 32'(g.sh));
    if (|eg) begin
      q.push_back(ref_rsp(g, eg[1], cyc + 3));
      last = eg[1];
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0; hold = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    q.delete();
    last = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    chk("rst_rsp_result", 32'({rsp1_result, rsp0_result}), 32'd0);
    chk("rst_rsp_flags", 32'({rsp1_flags, rsp0_flags}), 32'd0);
    chk("rst_rsp_err", 32'({rsp1_err, rsp0_err}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  always @(negedge clk) begin
    m_ev = q.size() > 0 && q[0].due == cyc;
    m_expv = m_ev ? (q[0].id ? 2'b10 : 2'b01) : 2'b00;
    m_eb = 1'b0;
    foreach (q[i]) if (q[i].due - 2 <= cyc) m_eb = 1'b1;
    chk("rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'(m_expv));
    chk("busy", 32'(busy), 32'(m_eb));
    if (m_ev) begin
      m_e = q.pop_front();
      chk("rsp_result", 32'(m_e.id ? rsp1_result : rsp0_result), 32'(m_e.res));
      chk("rsp_flags", 32'(m_e.id ? rsp1_flags : rsp0_flags), 32'(m_e.flags));
      chk("rsp_err", 32'(m_e.id ? rsp1_err : rsp0_err), 32'(m_e.err));
    end
  end

  initial begin
    idle = mk(1'b0, 4'd0, '0, '0, 5'd0);
    reset_dut();
    issue(mk(1'b1, 4'd0, 16'hffff, 16'h0001, 5'd0), idle, 1'b0);
    repeat (4) issue(idle, idle, 1'b0);
    reset_dut();
    repeat (4) issue(mk(1'b1, 4'd2, 16'd3, 16'd5, 5'd0), mk(1'b1, 4'd5, 16'h00ff, 16'h0f0f, 5'd0), 1'b0);
    issue(idle, mk(1'b1, 4'd3, 16'h1234, 16'h1234, 5'd0), 1'b0);
    issue(idle, mk(1'b1, 4'd12, 16'hbeef, 16'h0001, 5'd0), 1'b0);
    issue(mk(1'b1, 4'd1, 16'h0001, 16'h0002, 5'd0), idle, 1'b0);
    issue(mk(1'b1, 4'd6, 16'h8000, 16'h0000, 5'd4), idle, 1'b0);
    repeat (4) issue(idle, idle, 1'b0);
    issue(mk(1'b1, 4'd0, 16'd10, 16'd20, 5'd0), mk(1'b1, 4'd8, 16'd7, 16'd9, 5'd0), 1'b0);
    issue(mk(1'b1, 4'd1, 16'd50, 16'd8, 5'd0), mk(1'b1, 4'd2, 16'd4, 16'd4, 5'd0), 1'b0);
    reset_dut();
    repeat (3) issue(idle, idle, 1'b0);
    issue(mk(1'b1, 4'd0, 16'd1, 16'd1, 5'd0), mk(1'b1, 4'd0, 16'd2, 16'd2, 5'd0), 1'b0);
    issue(mk(1'b1, 4'd8, 16'h00aa, 16'h0055, 5'd0), mk(1'b1, 4'd0, 16'h8000, 16'h8000, 5'd0), 1'b0);
    repeat (6) issue(mk(1'b1, 4'd0, 16'd3, 16'd4, 5'd0), mk(1'b1, 4'd1, 16'd9, 16'd2, 5'd0), 1'b1);
    for (int n = 0; n < 400; n++) begin
      if (n == 200) reset_dut();
      issue(mk($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), W'($urandom), W'($urandom), 5'($urandom_range(0, 31))),
            mk($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), W'($urandom), W'($urandom), 5'($urandom_range(0, 31))),
            $urandom_range(0, 9) == 0);
    end
    for (int k = 0; k < 20 && q.size() > 0; k++) issue(idle, idle, 1'b0);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", q.size());
    end
    repeat (3) issue(idle, idle, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, meaning: operand/result width, equal to the shared ALU width.
REQ-002 Parameter ALU_LAT, default 2, meaning: ALU issue-to-result latency in clock edges; fixed by the shared pipelined ALU.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 reqN_valid  input  1  (N=0,1) request present.
REQ-006 reqN_ready  output  1  request accepted this cycle.
REQ-007 reqN_opcode  input  4  ALU opcode: ADD=0, SUB=1, MUL=2, SEQ=3, SNE=4, NAND=5, SRA=6, SLTU=7, MAX=8.
REQ-008 reqN_a, reqN_b  input  WIDTH  operands.
REQ-009 reqN_shamt  input  5  shift amount for SRA.
REQ-010 alu_opcode, alu_input1, alu_input2, alu_shift  output  4/WIDTH/WIDTH/5  driven to the shared ALU.
REQ-011 alu_result  input  WIDTH; alu_carry  input  1  shared ALU outputs.
REQ-012 rspN_valid  output  1  single-cycle response pulse; no backpressure.
REQ-013 rspN_result  output  WIDTH; rspN_flags  output  3  {carry, zero, sign}; rspN_err  output  1  unsupported opcode.
REQ-014 hold  input  1  when high, no new grants; in-flight work drains.
REQ-015 busy  output  1  high while any request is in flight or a response is pending.

Function
REQ-016 Arbitration SHALL be two-way round-robin: when both valid, grant the requester not granted most recently; a single valid requester is granted immediately.
REQ-017 reqN_ready SHALL be combinational: high only for the granted requester, only when its valid is high and hold is low; at most one ready per cycle.
REQ-018 On grant, alu_* outputs SHALL carry the granted request's fields in the same cycle; with no grant they SHALL be driven to opcode 0 and all-zero operands.
REQ-019 A tag {valid, id, err, is_arith} SHALL be shifted through an ALU_LAT-deep pipeline; accepted at edge N, response registered at edge N+ALU_LAT+... i.e. rspN_valid is high in the cycle after edge N+2.
REQ-020 Opcodes 3, 4, 7 and 9-15 are unsupported: the request SHALL be accepted normally, consume one issue slot, and return err=1, result 0, flags 0 with the same latency.
REQ-021 For supported opcodes, rsp result SHALL equal alu_result; zero = (result==0) and sign = result[WIDTH-1], computed in this block.
REQ-022 carry SHALL equal alu_carry for ADD and SUB, and SHALL be forced to 0 for all other opcodes.
REQ-023 Responses SHALL return in issue order; back-to-back grants SHALL sustain one response per cycle.
REQ-024 Simultaneous requests on consecutive cycles SHALL alternate 0,1,0,1...; a requester deasserting valid forfeits its turn without stalling the other.
REQ-025 Asserting hold SHALL not cancel in-flight tags; busy SHALL fall the cycle after the last response pulse.

Reset
REQ-026 While rst is low at a clock edge: all tags cleared, rspN_valid=0, rspN_result=0, rspN_flags=0, rspN_err=0, busy=0, round-robin pointer set so requester 0 wins the first tie.
REQ-027 Reset mid-operation SHALL discard all in-flight requests; no response pulses for them after reset releases.
REQ-028 The ALU's own reset is driven by the integrator (inverted rst); this block does not depend on ALU reset state.

Structure
REQ-029 Opcode constants, ALU_LAT, flag bit indices and the supported-opcode predicate SHALL live in shared package alu_ctrl_pkg.
REQ-030 Round-robin grant logic SHALL be a sub-module rr_arb2 (inputs: two valids, hold; outputs: one-hot grant; internal last-grant register).

Verification
REQ-031 Reset then req0 ADD a=0xFFFF b=0x0001 -> rsp0_valid 3 edges after accept, result 0x0000, flags carry=1 zero=1 sign=0.
REQ-032 Both valid for 4 cycles (req0 MUL 3*5, req1 NAND 0x00FF,0x0F0F) -> grants 0,1,0,1; rsp0 result 0x000F, rsp1 result 0xFFF0 sign=1, alternating pulses.
REQ-033 req1 SEQ (opcode 3) and opcode 12 -> accepted, rsp1_err=1, result 0, flags 0, latency unchanged.
REQ-034 req0 SRA a=0x8000 shamt=4 -> result 0xF800, carry=0, sign=1; preceding SUB 0x0001-0x0002 response has carry=1, result 0xFFFF.
REQ-035 Issue 2 back-to-back requests then drive rst low for one cycle -> no rsp pulses afterward, busy=0, next tie grants requester 0.
REQ-036 hold high with both valid -> both ready stay 0, in-flight responses still delivered, busy drops after last pulse.
